peripheral_bus_bridge: RTL

Parametrised I/O chipset bridge between the internal 8-bit bus and up to eight on-board peripheral slots (DMA, PIC, PIT, PPI, page register, …). It decodes 32-byte I/O blocks into per-slot chip selects and returns read data with fixed priority. It also inserts per-slot wait states on `io_channel_ready`, and lets a slot stretch the cycle. It replaces the fixed-decode, zero-wait chip-select/read-mux logic of the current peripheral block.

---
 rtl/peripheral_bus_pkg.sv | 20 ++
 rtl/peripheral_bus_decoder.sv | 27 ++
 rtl/peripheral_bus_bridge.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/peripheral_bus_pkg.sv
// peripheral_bus_pkg: shared types and helpers for the peripheral bus bridge.
package peripheral_bus_pkg;

  localparam int MAX_SLOTS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } bus_state_t;

  // Extract the 4-bit wait-state count for slot idx from the packed table.
  function automatic logic [3:0] slot_wait(input logic [31:0] wait_vec,
                                           input logic [4:0]  idx);
    logic [31:0] shifted;
    shifted = wait_vec >> {idx, 2'b00};
    return shifted[3:0];
  endfunction

endpackage

// File: rtl/peripheral_bus_decoder.sv
// peripheral_bus_decoder: combinational 32-byte I/O block decode into
// a slot index, a hit flag and one-hot-or-none active-low chip selects.
module peripheral_bus_decoder #(
  parameter int unsigned N_SLOTS    = 8,
  parameter logic [4:0]  BASE_BLOCK = 5'd0
) (
  input  logic [4:0]         block,
  input  logic               address_enable_n,
  output logic               hit,
  output logic [4:0]         sel,
  output logic [N_SLOTS-1:0] chip_select_n
);

  localparam logic [5:0] SLOT_COUNT = 6'(N_SLOTS);

  // Slot index is a 5-bit modular offset from the base block, so blocks
  // below BASE_BLOCK wrap to large values and fall outside the slot range.
  always_comb begin
    sel           = block - BASE_BLOCK;
    hit           = ~address_enable_n & ({1'b0, sel} < SLOT_COUNT);
    chip_select_n = '1;
    for (int i = 0; i < int'(N_SLOTS); i++) begin
      if (hit && (sel == 5'(i))) chip_select_n[i] = 1'b0;
    end
  end

endmodule

// File: rtl/peripheral_bus_bridge.sv
// peripheral_bus_bridge: I/O chipset bridge with slot decode, priority read
// mux and per-slot wait-state / stretch handshake on io_channel_ready.
// Optional stretch timeout with sticky bus_error: define PERIPHERAL_BUS_TIMEOUT_EN.
module peripheral_bus_bridge
  import peripheral_bus_pkg::*;
#(
  parameter int unsigned N_SLOTS        = 8,
  parameter logic [4:0]  BASE_BLOCK     = 5'd0,
  parameter logic [31:0] SLOT_WAIT      = 32'h0,
  parameter int unsigned INTA_SLOT      = 1,
  parameter logic [7:0]  OPEN_BUS_VALUE = 8'hFF,
  parameter logic [7:0]  TIMEOUT        = 8'd255
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [19:0]            address,
  input  logic                   address_enable_n,
  input  logic                   io_read_n,
  input  logic                   io_write_n,
  input  logic                   interrupt_acknowledge_n,
  input  logic [8*N_SLOTS-1:0]   slot_data_in,
  input  logic [N_SLOTS-1:0]     slot_ready,
  output logic [N_SLOTS-1:0]     chip_select_n,
  output logic [7:0]             data_bus_out,
  output logic                   data_bus_out_from_chipset,
  output logic                   io_channel_ready,
  output logic                   bus_error,
  input  logic                   bus_error_clear
);

  logic               hit;
  logic [4:0]         sel;
  logic [N_SLOTS-1:0] dec_cs_n;
  logic               strobe;
  logic [7:0]         sel_data;
  logic [7:0]         inta_data;
  logic               ready_sel;
  logic               ready_sel_q;
  logic               need_wait;
  logic               ready_comb;

  bus_state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [4:0] sel_q, sel_d;

  logic unused_addr;
  assign unused_addr = ^{address[19:10], address[4:0]};

  peripheral_bus_decoder #(
    .N_SLOTS    (N_SLOTS),
    .BASE_BLOCK (BASE_BLOCK)
  ) u_decoder (
    .block            (address[9:5]),
    .address_enable_n (address_enable_n),
    .hit              (hit),
    .sel              (sel),
    .chip_select_n    (dec_cs_n)
  );

  assign strobe    = hit & (~io_read_n | ~io_write_n);
  assign inta_data = slot_data_in[8*INTA_SLOT +: 8];

  // Per-slot lookups: data and ready for the live decode, ready for the latched slot.
  always_comb begin
    sel_data    = 8'h00;
    ready_sel   = 1'b0;
    ready_sel_q = 1'b0;
    for (int i = 0; i < int'(N_SLOTS); i++) begin
      if (sel == 5'(i)) begin
        sel_data  = slot_data_in[8*i +: 8];
        ready_sel = slot_ready[i];
      end
      if (sel_q == 5'(i)) ready_sel_q = slot_ready[i];
    end
  end

  // Priority read mux: INTA, then slot read, then open bus, else idle.
  always_comb begin
    data_bus_out              = 8'h00;
    data_bus_out_from_chipset = 1'b0;
    if (!interrupt_acknowledge_n) begin
      data_bus_out              = inta_data;
      data_bus_out_from_chipset = 1'b1;
    end else if (strobe && !io_read_n) begin
      data_bus_out              = sel_data;
      data_bus_out_from_chipset = 1'b1;
    end else if (!address_enable_n && !io_read_n && !hit) begin
      data_bus_out              = OPEN_BUS_VALUE;
      data_bus_out_from_chipset = 1'b1;
    end
  end

  // INTA cycles complete without wait states even if a slot strobe overlaps.
  assign need_wait = interrupt_acknowledge_n &
                     ((slot_wait(SLOT_WAIT, sel) != 4'd0) | ~ready_sel);

`ifdef PERIPHERAL_BUS_TIMEOUT_EN
  logic [7:0] to_cnt_q, to_cnt_d;
  logic       bus_error_q, bus_error_d;
  logic       timeout_hit;

  assign timeout_hit = (state_q == WAIT) && strobe &&
                       (({1'b0, to_cnt_q} + 9'd1) == {1'b0, TIMEOUT});

  // Stretch watchdog: cleared while idle, counts WAIT cycles; set beats clear.
  always_comb begin
    to_cnt_d    = to_cnt_q;
    bus_error_d = bus_error_q;
    if (state_q == IDLE)      to_cnt_d = 8'd0;
    else if (state_q == WAIT) to_cnt_d = to_cnt_q + 8'd1;
    if (bus_error_clear) bus_error_d = 1'b0;
    if (timeout_hit)     bus_error_d = 1'b1;
  end

  // Watchdog registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      to_cnt_q    <= 8'd0;
      bus_error_q <= 1'b0;
    end else begin
      to_cnt_q    <= to_cnt_d;
      bus_error_q <= bus_error_d;
    end
  end

  assign bus_error = bus_error_q;
`else
  logic unused_clear;
  assign unused_clear = bus_error_clear;
  assign bus_error    = 1'b0;
`endif

  // Wait FSM next-state and combinational ready request.
  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    ready_comb = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (strobe) begin
          sel_d = sel;
          cnt_d = slot_wait(SLOT_WAIT, sel);
          if (need_wait) begin
            state_d    = WAIT;
            ready_comb = 1'b0;
          end else begin
            state_d = DONE;
          end
        end
      end
      WAIT: begin
        ready_comb = 1'b0;
        cnt_d      = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
        if (!strobe) begin
          state_d = IDLE;
        end else if ((cnt_q <= 4'd1) && ready_sel_q) begin
          state_d = DONE;
`ifdef PERIPHERAL_BUS_TIMEOUT_EN
        end else if (timeout_hit) begin
          state_d = DONE;
`endif
        end
      end
      DONE: begin
        if (!strobe) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, wait counter and latched slot.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      sel_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
    end
  end

  // Reset releases the CPU and deselects every slot without waiting for a clock.
  assign io_channel_ready = reset | ready_comb;
  assign chip_select_n    = reset ? '1 : dec_cs_n;

endmodule
